pe_mac_stream: RTL and testbench

- Parametrised systolic processing element, successor to the fixed 32-bit PE.
- Each cycle it accepts one operand pair and forwards the pair east/south to neighbouring PEs one cycle later.
- Products go through a MUL_LAT-stage pipelined multiplier and are accumulated into a wide accumulator.
- first/last tags delimit dot products, with signed/unsigned selection per element and a one-cycle result strobe.

---
 rtl/pe_mac_stream.sv | 214 +++++++++++++++++++++
 tb/tb_pe_mac_stream.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_stream.sv
// pe_mac_stream: systolic multiply-accumulate processing element.
//
// Each valid operand pair is registered and forwarded east/south one cycle
// later. The product then runs through a MUL_LAT-stage multiplier pipeline and
// is accumulated into an ACC_W-bit accumulator. first/last tags delimit a dot
// product. Each element selects signed or unsigned arithmetic.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid             operand pair present this cycle
//   in_first/in_last     dot-product delimiters (qualified by in_valid)
//   in_signed            1 = two's-complement element, 0 = unsigned
//   a_in, b_in           row / column operands
//   a_out, b_out         registered operands to east / south neighbours
//   fwd_valid/first/last/signed  registered element tags
//   acc_out              last completed dot product, held until the next one
//   acc_valid            one-cycle strobe when acc_out updates
//   busy                 an element is in the operand register or the pipeline
//   overflow             sticky saturation flag
//
// Build option: define PE_MAC_SAT_EN for saturating accumulation and a live
// overflow flag. Without it the accumulator wraps and overflow is tied to 0.

module pe_mac_stream #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  input  logic              in_signed,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              fwd_valid,
  output logic              fwd_first,
  output logic              fwd_last,
  output logic              fwd_signed,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned FIN    = MUL_LAT - 1;

  // Operand register, doubles as the forwarding register.
  logic              op_valid_q, op_valid_d;
  logic              op_first_q, op_first_d;
  logic              op_last_q, op_last_d;
  logic              op_signed_q, op_signed_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;

  // Multiplier pipeline; index FIN is the stage that feeds the accumulator.
  logic [PROD_W-1:0]  mul_prod_q [MUL_LAT];
  logic [PROD_W-1:0]  mul_prod_d [MUL_LAT];
  logic [MUL_LAT-1:0] mul_valid_q, mul_valid_d;
  logic [MUL_LAT-1:0] mul_first_q, mul_first_d;
  logic [MUL_LAT-1:0] mul_last_q, mul_last_d;
  logic [MUL_LAT-1:0] mul_signed_q, mul_signed_d;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  acc_out_q, acc_out_d;
  logic              acc_valid_q, acc_valid_d;

  logic [PROD_W-1:0] a_ext, b_ext, prod;
  logic [ACC_W-1:0]  prod_ext, acc_base, acc_next;
  logic              fin_valid, fin_first, fin_last, fin_signed;
  logic [PROD_W-1:0] fin_prod;

`ifdef PE_MAC_SAT_EN
  logic [ACC_W:0]    sum_wide;
  logic              sat_hit;
  logic              overflow_q, overflow_d;
`endif

  // Tags are masked by in_valid so idle cycles never carry stale tags.
  always_comb begin
    op_valid_d  = in_valid;
    op_first_d  = in_valid & in_first;
    op_last_d   = in_valid & in_last;
    op_signed_d = in_valid & in_signed;
    op_a_d      = in_valid ? a_in : op_a_q;
    op_b_d      = in_valid ? b_in : op_b_q;
  end

  // Extending both operands to PROD_W and keeping the low PROD_W bits of the
  // product yields the correct signed or unsigned product with one multiplier.
  always_comb begin
    if (op_signed_q) begin
      a_ext = PROD_W'($signed(op_a_q));
      b_ext = PROD_W'($signed(op_b_q));
    end else begin
      a_ext = PROD_W'(op_a_q);
      b_ext = PROD_W'(op_b_q);
    end
    prod = a_ext * b_ext;
  end

  always_comb begin
    mul_prod_d[0]   = prod;
    mul_valid_d[0]  = op_valid_q;
    mul_first_d[0]  = op_first_q;
    mul_last_d[0]   = op_last_q;
    mul_signed_d[0] = op_signed_q;
    for (int unsigned i = 1; i < MUL_LAT; i++) begin
      mul_prod_d[i]   = mul_prod_q[i-1];
      mul_valid_d[i]  = mul_valid_q[i-1];
      mul_first_d[i]  = mul_first_q[i-1];
      mul_last_d[i]   = mul_last_q[i-1];
      mul_signed_d[i] = mul_signed_q[i-1];
    end
  end

  assign fin_prod   = mul_prod_q[FIN];
  assign fin_valid  = mul_valid_q[FIN];
  assign fin_first  = mul_first_q[FIN];
  assign fin_last   = mul_last_q[FIN];
  assign fin_signed = mul_signed_q[FIN];

  always_comb begin
    if (fin_signed) prod_ext = ACC_W'($signed(fin_prod));
    else            prod_ext = ACC_W'(fin_prod);
    acc_base = fin_first ? '0 : acc_q;
`ifdef PE_MAC_SAT_EN
    sat_hit = 1'b0;
    if (fin_signed) begin
      sum_wide = {acc_base[ACC_W-1], acc_base} + {prod_ext[ACC_W-1], prod_ext};
      acc_next = sum_wide[ACC_W-1:0];
      // Top two bits disagree: result left the signed range; clamp by true sign.
      if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
        sat_hit  = 1'b1;
        acc_next = {sum_wide[ACC_W], {(ACC_W-1){~sum_wide[ACC_W]}}};
      end
    end else begin
      sum_wide = {1'b0, acc_base} + {1'b0, prod_ext};
      acc_next = sum_wide[ACC_W-1:0];
      if (sum_wide[ACC_W]) begin
        sat_hit  = 1'b1;
        acc_next = '1;
      end
    end
    // A first-tagged element restarts the sticky flag.
    overflow_d = fin_valid ? ((fin_first ? 1'b0 : overflow_q) | sat_hit) : overflow_q;
`else
    acc_next = acc_base + prod_ext;
`endif
    acc_d       = fin_valid ? acc_next : acc_q;
    acc_valid_d = fin_valid & fin_last;
    acc_out_d   = acc_valid_d ? acc_next : acc_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid_q   <= 1'b0;
      op_first_q   <= 1'b0;
      op_last_q    <= 1'b0;
      op_signed_q  <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      for (int unsigned i = 0; i < MUL_LAT; i++) mul_prod_q[i] <= '0;
      mul_valid_q  <= '0;
      mul_first_q  <= '0;
      mul_last_q   <= '0;
      mul_signed_q <= '0;
      acc_q        <= '0;
      acc_out_q    <= '0;
      acc_valid_q  <= 1'b0;
`ifdef PE_MAC_SAT_EN
      overflow_q   <= 1'b0;
`endif
    end else begin
      op_valid_q   <= op_valid_d;
      op_first_q   <= op_first_d;
      op_last_q    <= op_last_d;
      op_signed_q  <= op_signed_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      for (int unsigned i = 0; i < MUL_LAT; i++) mul_prod_q[i] <= mul_prod_d[i];
      mul_valid_q  <= mul_valid_d;
      mul_first_q  <= mul_first_d;
      mul_last_q   <= mul_last_d;
      mul_signed_q <= mul_signed_d;
      acc_q        <= acc_d;
      acc_out_q    <= acc_out_d;
      acc_valid_q  <= acc_valid_d;
`ifdef PE_MAC_SAT_EN
      overflow_q   <= overflow_d;
`endif
    end
  end

  assign a_out      = op_a_q;
  assign b_out      = op_b_q;
  assign fwd_valid  = op_valid_q;
  assign fwd_first  = op_first_q;
  assign fwd_last   = op_last_q;
  assign fwd_signed = op_signed_q;
  assign acc_out    = acc_out_q;
  assign acc_valid  = acc_valid_q;
  assign busy       = op_valid_q | (|mul_valid_q);
`ifdef PE_MAC_SAT_EN
  assign overflow   = overflow_q;
`else
  assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_pe_mac_stream.sv
// Bench for pe_mac_stream: two instances (ACC_W=24 and ACC_W=16) share one
// randomized input stream. Expected dot-product results are pushed into
// per-instance queues at issue time and popped by a negedge monitor.

module tb_pe_mac_stream;

  localparam int unsigned DW  = 8;
  localparam int unsigned LAT = 2;

  typedef struct {
    longint acc;
    bit     ovf;
    int     cyc;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          in_valid, in_first, in_last, in_signed;
  logic [DW-1:0] a_in, b_in;

  logic [DW-1:0] a_out0, b_out0, a_out1, b_out1;
  logic          fv0, ff0, fl0, fs0, fv1, ff1, fl1, fs1;
  logic [23:0]   acc_out0;
  logic [15:0]   acc_out1;
  logic          av0, av1, busy0, busy1, ovf0, ovf1;

  pe_mac_stream #(.DATA_W(DW), .ACC_W(24), .MUL_LAT(LAT)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .in_signed(in_signed), .a_in(a_in), .b_in(b_in), .a_out(a_out0), .b_out(b_out0),
    .fwd_valid(fv0), .fwd_first(ff0), .fwd_last(fl0), .fwd_signed(fs0),
    .acc_out(acc_out0), .acc_valid(av0), .busy(busy0), .overflow(ovf0)
  );

  pe_mac_stream #(.DATA_W(DW), .ACC_W(16), .MUL_LAT(LAT)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .in_signed(in_signed), .a_in(a_in), .b_in(b_in), .a_out(a_out1), .b_out(b_out1),
    .fwd_valid(fv1), .fwd_first(ff1), .fwd_last(fl1), .fwd_signed(fs1),
    .acc_out(acc_out1), .acc_valid(av1), .busy(busy1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t   q0[$];
  exp_t   q1[$];
  longint m_acc[2];
  bit     m_ovf[2];
  longint hold[2];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic flag_fail(input string name, input string msg);
    n_checks++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  function automatic int acc_w(input int k);
    return (k == 0) ? 24 : 16;
  endfunction

  // Reference: a dot product is a running sum of exact products, reduced to
  // ACC_W bits by wrapping or (with saturation) clamping at the range limits.
  task automatic model_elem(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input bit f, input bit l, input bit s);
    longint p, base, r, lim, mask, smax, smin;
    int w;
    exp_t e;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'(a) * longint'(b);
    for (int k = 0; k < 2; k++) begin
      w    = acc_w(k);
      lim  = longint'(1) << w;
      mask = lim - 1;
`ifdef PE_MAC_SAT_EN
      smax = (longint'(1) << (w - 1)) - 1;
      smin = -(longint'(1) << (w - 1));
      if (f) m_ovf[k] = 1'b0;
      if (s) begin
        base = f ? 0 : ((m_acc[k] > smax) ? m_acc[k] - lim : m_acc[k]);
        r = base + p;
        if (r > smax) begin r = smax; m_ovf[k] = 1'b1; end
        if (r < smin) begin r = smin; m_ovf[k] = 1'b1; end
      end else begin
        base = f ? 0 : m_acc[k];
        r = base + p;
        if (r > mask) begin r = mask; m_ovf[k] = 1'b1; end
      end
`else
      smax = 0;
      smin = 0;
      base = f ? 0 : m_acc[k];
      r = base + p;
`endif
      m_acc[k] = r & mask;
      if (l) begin
        e.acc = m_acc[k];
        e.ovf = m_ovf[k];
        e.cyc = cyc + LAT + 2;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input bit f, input bit l, input bit s);
    @(posedge clk);
    #1;
    in_valid  = v;
    a_in      = a;
    b_in      = b;
    in_first  = f;
    in_last   = l;
    in_signed = s;
    if (v) model_elem(a, b, f, l, s);
  endtask

  // Idle cycle with junk tags, which the DUT must ignore.
  task automatic idle();
    drive(1'b0, DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0;
      m_ovf[k] = 1'b0;
      hold[k]  = 0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy0) && n < 40) begin
      idle();
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) flag_fail("drain", "results still pending");
    idle();
    idle();
    @(negedge clk);
  endtask

  // Forwarding / busy expectations: an element is visible on the forward
  // ports for one cycle and keeps the PE busy for LAT+1 cycles.
  logic [DW-1:0] e_a, e_b;
  logic          e_fv, e_f, e_l, e_s;
  logic [LAT:0]  hist;

  always @(posedge clk) begin
    if (rst) begin
      e_fv <= 1'b0; e_a <= '0; e_b <= '0; hist <= '0;
      e_f  <= 1'b0; e_l <= 1'b0; e_s <= 1'b0;
    end else begin
      e_fv <= in_valid;
      hist <= {hist[LAT-1:0], in_valid};
      if (in_valid) begin
        e_a <= a_in; e_b <= b_in; e_f <= in_first; e_l <= in_last; e_s <= in_signed;
      end
    end
  end

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void qpop(input int k);
    if (k == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  task automatic check_acc(input int k, input bit av, input longint acc, input bit ovf);
    exp_t e;
    if (av) begin
      if (qsize(k) == 0) begin
        flag_fail($sformatf("acc_valid%0d", k), "strobe with no result expected");
      end else begin
        e = qfront(k);
        qpop(k);
        chk($sformatf("acc_out%0d", k), acc, e.acc);
        chk($sformatf("overflow%0d", k), longint'(ovf), longint'(e.ovf));
        chk($sformatf("latency%0d", k), longint'(cyc), longint'(e.cyc));
        hold[k] = e.acc;
      end
    end else if (qsize(k) != 0) begin
      e = qfront(k);
      if (e.cyc <= cyc) begin
        flag_fail($sformatf("acc_valid%0d", k), $sformatf("missing strobe due cycle %0d", e.cyc));
        qpop(k);
        hold[k] = e.acc;
      end
    end
    chk($sformatf("acc_hold%0d", k), acc, hold[k]);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("fwd_valid0", longint'(fv0), longint'(e_fv));
      chk("a_out0", longint'(a_out0), longint'(e_a));
      chk("b_out0", longint'(b_out0), longint'(e_b));
      chk("fwd_valid1", longint'(fv1), longint'(e_fv));
      chk("a_out1", longint'(a_out1), longint'(e_a));
      chk("b_out1", longint'(b_out1), longint'(e_b));
      if (e_fv) begin
        chk("fwd_tags0", longint'({ff0, fl0, fs0}), longint'({e_f, e_l, e_s}));
        chk("fwd_tags1", longint'({ff1, fl1, fs1}), longint'({e_f, e_l, e_s}));
      end
      chk("busy0", longint'(busy0), longint'(|hist));
      chk("busy1", longint'(busy1), longint'(|hist));
      check_acc(0, av0, longint'(acc_out0), ovf0);
      check_acc(1, av1, longint'(acc_out1), ovf1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit v;
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_signed = 1'b0;
    a_in = '0; b_in = '0;
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_ovf[k] = 1'b0; hold[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_acc_valid", longint'({av0, av1}), 0);
    chk("reset_overflow", longint'({ovf0, ovf1}), 0);
    chk("reset_acc_out", longint'(acc_out0), 0);

    // Signed two-element dot product: -15 + -14 = -29.
    drive(1'b1, 8'hFD, 8'h05, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'h07, 8'hFE, 1'b0, 1'b1, 1'b1);
    drain();
    chk("signed_dot", longint'(acc_out0), longint'(24'hFFFFE3));

    // Unsigned 3 * 255 * 255.
    drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    drain();
    chk("unsigned_dot", longint'(acc_out0), longint'(24'h02FA03));

    // Back-to-back length-1 dot products.
    drive(1'b1, 8'd2, 8'd3, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 8'd4, 8'd4, 1'b1, 1'b1, 1'b1);
    drain();
    chk("b2b_last", longint'(acc_out0), 16);

    // 3 * 127 * 127 = 48387 exceeds the 16-bit signed range.
    drive(1'b1, 8'd127, 8'd127, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'd127, 8'd127, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'd127, 8'd127, 1'b0, 1'b1, 1'b1);
    drain();
    chk("wide_no_sat", longint'(acc_out0), longint'(24'h00BD03));
    chk("wide_no_ovf", longint'(ovf0), 0);
`ifdef PE_MAC_SAT_EN
    chk("narrow_sat", longint'(acc_out1), longint'(16'h7FFF));
    chk("narrow_ovf", longint'(ovf1), 1);
`else
    chk("narrow_wrap", longint'(acc_out1), longint'(16'hBD03));
    chk("narrow_ovf", longint'(ovf1), 0);
`endif

    // Reset one cycle after a last-tagged element enters: nothing completes.
    drive(1'b1, 8'd9, 8'd9, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'd3, 8'd3, 1'b0, 1'b1, 1'b0);
    do_reset();
    repeat (6) idle();
    @(negedge clk);
    chk("rst_acc_out", longint'(acc_out0), 0);
    chk("rst_busy", longint'(busy0), 0);
    chk("rst_overflow", longint'(ovf1), 0);
    drive(1'b1, 8'd1, 8'd1, 1'b1, 1'b1, 1'b1);
    drain();
    chk("post_rst_dot", longint'(acc_out0), 1);

    // Random stream: mixed signedness, arbitrary tags, gaps.
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      drive(v, DW'($urandom), DW'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0), 1'($urandom));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
